ldp_transport_ctrl: RTL

- Transport sequencer for the virtual laserdisc player.
- Turns play/pause/frame-search requests into an ordered series of MPEG decoder register writes and stream-seek handshakes with the HPS stream source.
- Tracks the current frame number from decoder vsync and reports player status.
- Sits between the HPS command path and the MPEG decoder register port, inside the VLDP top level.

---
 rtl/ldp_transport_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ldp_transport_ctrl.sv
// Transport sequencer for the virtual laserdisc player: turns play/pause/search
// requests into MPEG decoder register writes and stream-seek handshakes.
module ldp_transport_ctrl #(
  parameter logic [4:0]  REG_CTRL     = 5'd0,
  parameter logic [4:0]  REG_FLUSH    = 5'd1,
  parameter logic [31:0] MAX_FRAME    = 32'd54000,
  parameter logic [23:0] SEEK_TIMEOUT = 24'd12_000_000
) (
  input  logic        sys_clk,
  input  logic        RESET_N,
  input  logic        play_req,
  input  logic        pause_req,
  input  logic        search_req,
  input  logic [31:0] search_frame,
  input  logic        mpeg_busy,
  input  logic        v_sync,
  input  logic        seek_ack,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [31:0] reg_dta_in,
  output logic        seek_req,
  output logic [31:0] seek_frame,
  output logic [31:0] cur_frame,
  output logic        is_playing,
  output logic        is_paused,
  output logic        is_searching,
  output logic        seek_error
);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_SEEK   = 3'd4,
    ST_RESUME = 3'd5
  } state_t;

  localparam logic [31:0] CTRL_RUN    = 32'h0000_0001;
  localparam logic [31:0] CTRL_FREEZE = 32'h0000_0003;
  localparam logic [31:0] FLUSH_GO    = 32'h0000_0001;

  state_t      r_state, w_state_nxt;
  state_t      r_wr_next, w_wr_next;
  logic        r_wr_pend;
  logic [4:0]  r_reg_addr, w_q_addr;
  logic [31:0] r_reg_dta, w_q_dta;
  logic        w_queue, w_wr_fire, w_vs_rise, w_tmo_hit, w_frame_inc, w_eod;
  logic        w_accept_search, w_seek_done, w_seek_abort;
  logic        r_vs_d;
  logic [23:0] r_tmo_cnt;
  logic        r_seek_req, r_seek_error;
  logic [31:0] r_seek_frame, r_cur_frame, w_target;
  logic        r_is_playing, r_is_paused, r_is_searching;

  // A queued write issues in the first cycle the decoder is not busy.
  assign w_wr_fire   = r_wr_pend & ~mpeg_busy;
  assign w_vs_rise   = v_sync & ~r_vs_d;
  assign w_tmo_hit   = (r_tmo_cnt == (SEEK_TIMEOUT - 24'd1));
  assign w_frame_inc = (r_state == ST_PLAY) & w_vs_rise;
  assign w_eod       = w_frame_inc & (r_cur_frame >= (MAX_FRAME - 32'd1));
  assign w_target    = (search_frame > MAX_FRAME) ? MAX_FRAME : search_frame;

  // Next-state selection and write-queue requests.
  always_comb begin
    w_state_nxt     = r_state;
    w_queue         = 1'b0;
    w_q_addr        = r_reg_addr;
    w_q_dta         = r_reg_dta;
    w_wr_next       = r_wr_next;
    w_accept_search = 1'b0;
    w_seek_done     = 1'b0;
    w_seek_abort    = 1'b0;
    case (r_state)
      ST_STOP, ST_PLAY, ST_PAUSE: begin
        if (r_wr_pend) begin
          if (w_wr_fire) begin
            w_state_nxt = r_wr_next;
          end else begin
            w_state_nxt = r_state;
          end
        end else if (search_req) begin
          w_accept_search = 1'b1;
          w_queue         = 1'b1;
          w_q_addr        = REG_FLUSH;
          w_q_dta         = FLUSH_GO;
          w_wr_next       = ST_SEEK;
          w_state_nxt     = ST_FLUSH;
        end else if (pause_req && (r_state == ST_PLAY)) begin
          w_queue   = 1'b1;
          w_q_addr  = REG_CTRL;
          w_q_dta   = CTRL_FREEZE;
          w_wr_next = ST_PAUSE;
        end else if (play_req && (r_state != ST_PLAY)) begin
          w_queue   = 1'b1;
          w_q_addr  = REG_CTRL;
          w_q_dta   = CTRL_RUN;
          w_wr_next = ST_PLAY;
        end else if (w_eod) begin
          // End of disc: freeze on the last frame.
          w_queue   = 1'b1;
          w_q_addr  = REG_CTRL;
          w_q_dta   = CTRL_FREEZE;
          w_wr_next = ST_PAUSE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FLUSH, ST_RESUME: begin
        if (w_wr_fire) begin
          w_state_nxt = r_wr_next;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_SEEK: begin
        if (seek_ack) begin
          w_seek_done = 1'b1;
          w_queue     = 1'b1;
          w_q_addr    = REG_CTRL;
          w_q_dta     = CTRL_FREEZE;
          w_wr_next   = ST_PAUSE;
          w_state_nxt = ST_RESUME;
        end else if (w_tmo_hit) begin
          w_seek_abort = 1'b1;
          w_state_nxt  = ST_PAUSE;
        end else begin
          w_state_nxt = ST_SEEK;
        end
      end
      default: begin
        w_state_nxt = ST_STOP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Single-entry write queue and decoder register port.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_pend  <= 1'b0;
      r_reg_addr <= 5'd0;
      r_reg_dta  <= 32'd0;
      r_wr_next  <= ST_STOP;
    end else if (w_queue) begin
      r_wr_pend  <= 1'b1;
      r_reg_addr <= w_q_addr;
      r_reg_dta  <= w_q_dta;
      r_wr_next  <= w_wr_next;
    end else if (w_wr_fire) begin
      r_wr_pend <= 1'b0;
    end else begin
      r_wr_pend <= r_wr_pend;
    end
  end

  // Seek handshake, timeout counter, error flag and frame tracking.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs_d       <= 1'b0;
      r_tmo_cnt    <= 24'd0;
      r_seek_req   <= 1'b0;
      r_seek_frame <= 32'd0;
      r_seek_error <= 1'b0;
      r_cur_frame  <= 32'd0;
    end else begin
      r_vs_d <= v_sync;
      if ((r_state == ST_SEEK) && !w_seek_done && !w_seek_abort) begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end else begin
        r_tmo_cnt <= 24'd0;
      end
      if ((r_state == ST_FLUSH) && w_wr_fire) begin
        r_seek_req <= 1'b1;
      end else if (w_seek_done || w_seek_abort) begin
        r_seek_req <= 1'b0;
      end else begin
        r_seek_req <= r_seek_req;
      end
      if (w_accept_search) begin
        r_seek_frame <= w_target;
        r_seek_error <= 1'b0;
      end else if (w_seek_abort) begin
        r_seek_error <= 1'b1;
      end else begin
        r_seek_error <= r_seek_error;
      end
      if (w_seek_done) begin
        r_cur_frame <= r_seek_frame;
      end else if (w_frame_inc && (r_cur_frame < MAX_FRAME)) begin
        r_cur_frame <= r_cur_frame + 32'd1;
      end else begin
        r_cur_frame <= r_cur_frame;
      end
    end
  end

  // Status flags follow the state register by one cycle.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_is_playing   <= 1'b0;
      r_is_paused    <= 1'b0;
      r_is_searching <= 1'b0;
    end else begin
      r_is_playing   <= (r_state == ST_PLAY);
      r_is_paused    <= (r_state == ST_PAUSE);
      r_is_searching <= (r_state == ST_FLUSH) || (r_state == ST_SEEK) ||
                        (r_state == ST_RESUME);
    end
  end

  assign reg_wr_en    = w_wr_fire;
  assign reg_addr     = r_reg_addr;
  assign reg_dta_in   = r_reg_dta;
  assign seek_req     = r_seek_req;
  assign seek_frame   = r_seek_frame;
  assign cur_frame    = r_cur_frame;
  assign is_playing   = r_is_playing;
  assign is_paused    = r_is_paused;
  assign is_searching = r_is_searching;
  assign seek_error   = r_seek_error;

endmodule
